// File: rtl/frac_sweep_pkg.sv
// Shared types, constants and the M-range check for the fractional divider sweep.
// Combinational helpers only.
package frac_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STEP,
    DONE,
    ERR
  } state_t;

  localparam int unsigned LOAD_CYCLES = 2;

  // M is legal when 1 <= M <= N+1, evaluated in 33 bits so N+1 cannot wrap.
  function automatic logic m_in_range(input logic [32:0] m, input logic [31:0] n);
    return (m != 33'd0) && (m <= ({1'b0, n} + 33'd1));
  endfunction

endpackage

// File: rtl/frac_sweep_edge_cnt.sv
// Counts both edges of div_clk while enabled and flags the edge that completes the dwell.
// Latency: reached is combinational on the current edge; count updates next cycle.
// Backpressure: none, clr has priority over counting.
module frac_sweep_edge_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] dwell,
  output logic        reached
);

  logic        div_clk_q;
  logic [31:0] cnt_q;
  logic        edge_det;
  logic [31:0] dwell_eff;

  assign edge_det  = div_clk ^ div_clk_q;
  assign dwell_eff = (dwell == 32'd0) ? 32'd1 : dwell;
  assign reached   = en && edge_det && ((cnt_q + 32'd1) == dwell_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_clk_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      div_clk_q <= div_clk;
      if (clr) begin
        cnt_q <= '0;
      end else if (en && edge_det) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/frac_clk_sweep_ctrl.sv
// Loads N/M into the fractional divider, holds it in reset, then steps M through a linear sweep.
// Latency: start -> divider released 3 cycles later; dwell edge -> new M 2 cycles later.
// Backpressure: start ignored while busy; abort wins over start. FRAC_SWEEP_LOOP_EN repeats the sweep.
module frac_clk_sweep_ctrl
  import frac_sweep_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   cfg_n,
  input  logic [31:0]   m_start,
  input  logic [31:0]   m_step,
  input  logic [CW-1:0] m_count,
  input  logic [31:0]   dwell,
  input  logic          div_clk,
  output logic [31:0]   div_n,
  output logic [31:0]   div_m,
  output logic          div_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] step_idx
);

  state_t        state_q, state_d;
  logic [1:0]    load_cnt_q, load_cnt_d;
  logic [31:0]   n_d, m_d;
  logic [CW-1:0] idx_d;
  logic          err_d, done_d, busy_d, run_d, cfg_ld;
  logic [31:0]   m_step_q, dwell_q;
  logic [CW-1:0] m_count_q;
`ifdef FRAC_SWEEP_LOOP_EN
  logic [31:0]   m_start_q;
`endif
  logic [32:0]   m_next;
  logic          start_ok, last_step, dwell_hit;

  assign start_ok  = (m_count != '0) && m_in_range({1'b0, m_start}, cfg_n);
  assign m_next    = {1'b0, div_m} + {1'b0, m_step_q};
  assign last_step = (step_idx == (m_count_q - CW'(1)));

  frac_sweep_edge_cnt u_edge_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .div_clk (div_clk),
    .clr     ((state_q == LOAD) || (state_q == STEP)),
    .en      (state_q == RUN),
    .dwell   (dwell_q),
    .reached (dwell_hit)
  );

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    n_d        = div_n;
    m_d        = div_m;
    idx_d      = step_idx;
    err_d      = err;
    done_d     = 1'b0;
    cfg_ld     = 1'b0;
    busy_d     = 1'b0;
    run_d      = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          if (start_ok) begin
            state_d    = LOAD;
            load_cnt_d = '0;
            n_d        = cfg_n;
            m_d        = m_start;
            idx_d      = '0;
            err_d      = 1'b0;
            cfg_ld     = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        load_cnt_d = load_cnt_q + 2'd1;
        if (load_cnt_q == 2'(LOAD_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (dwell_hit) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (last_step) begin
          done_d = 1'b1;
`ifdef FRAC_SWEEP_LOOP_EN
          state_d = RUN;
          m_d     = m_start_q;
          idx_d   = '0;
`else
          state_d = DONE;
`endif
        end else if (m_next[32] || !m_in_range(m_next, div_n)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          state_d = RUN;
          m_d     = m_next[31:0];
          idx_d   = step_idx + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort freezes the programmed values and error flag; only the sequencing stops.
    if (abort) begin
      state_d = IDLE;
      n_d     = div_n;
      m_d     = div_m;
      idx_d   = step_idx;
      err_d   = err;
      done_d  = 1'b0;
      cfg_ld  = 1'b0;
    end

    busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == STEP);
    run_d  = (state_d == RUN) || (state_d == STEP) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      div_n      <= '0;
      div_m      <= '0;
      div_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      step_idx   <= '0;
      m_step_q   <= '0;
      m_count_q  <= '0;
      dwell_q    <= '0;
`ifdef FRAC_SWEEP_LOOP_EN
      m_start_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      div_n      <= n_d;
      div_m      <= m_d;
      div_rst_n  <= run_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      step_idx   <= idx_d;
      if (cfg_ld) begin
        m_step_q  <= m_step;
        m_count_q <= m_count;
        dwell_q   <= dwell;
`ifdef FRAC_SWEEP_LOOP_EN
        m_start_q <= m_start;
`endif
      end
    end
  end

endmodule

// File: tb/tb_frac_clk_sweep_ctrl.sv
// Randomized bench for frac_clk_sweep_ctrl: expected M sequence and outcome are precomputed
// arithmetically per sweep, and div_clk edges are counted against the dwell as the bench drives them.
module tb_frac_clk_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] cfg_n;
  logic [31:0] m_start;
  logic [31:0] m_step;
  logic [15:0] m_count;
  logic [31:0] dwell;
  logic        div_clk;
  logic [31:0] div_n;
  logic [31:0] div_m;
  logic        div_rst_n;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] step_idx;

  int n_chk  = 0;
  int n_fail = 0;
  bit ev;

`ifdef FRAC_SWEEP_LOOP_EN
  localparam int LOOP_PASSES = 2;
`endif

  frac_clk_sweep_ctrl #(.CW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_n     (cfg_n),
    .m_start   (m_start),
    .m_step    (m_step),
    .m_count   (m_count),
    .dwell     (dwell),
    .div_clk   (div_clk),
    .div_n     (div_n),
    .div_m     (div_m),
    .div_rst_n (div_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .step_idx  (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_n"},    div_n, 0);
    check_val({tag, "_m"},    div_m, 0);
    check_val({tag, "_rstn"}, div_rst_n, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_err"},  err, 0);
    check_val({tag, "_idx"},  step_idx, 0);
  endtask

  // Advance one cycle; ev reports whether div_clk differs from its value in the previous cycle.
  task automatic cyc(output bit e);
    logic prev;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    prev  = div_clk;
    if ($urandom_range(0, 1) == 1) div_clk = ~div_clk;
    e = (div_clk != prev);
  endtask

  task automatic do_sweep(input logic [31:0] n, input logic [31:0] ms, input logic [31:0] mstep,
                          input logic [15:0] mcnt, input logic [31:0] dw);
    logic [63:0] mv [$];
    logic [63:0] v;
    logic [31:0] dw_eff;
    int          err_at, k, cnt, budget, pass;
    bit          e;
    logic        exp_done;

    dw_eff = (dw == 32'd0) ? 32'd1 : dw;
    err_at = -1;
    for (int i = 0; i < int'(mcnt); i++) begin
      v = 64'(ms) + 64'(i) * 64'(mstep);
      mv.push_back(v);
      if (err_at < 0 && (v == 64'd0 || v > 64'(n) + 64'd1 || v >= 64'h1_0000_0000)) err_at = i;
    end
    if (mcnt == 16'd0) err_at = 0;

    cfg_n = n; m_start = ms; m_step = mstep; m_count = mcnt; dwell = dw;
    start = 1'b1;
    cyc(e);
    if (err_at == 0) begin
      for (int i = 0; i < 3; i++) begin
        check_val("start_err", err, 1);
        check_val("start_err_rstn", div_rst_n, 0);
        check_val("start_err_busy", busy, 0);
        check_val("start_err_done", done, 0);
        cyc(e);
      end
      return;
    end

    for (int i = 0; i < 2; i++) begin
      check_val("load_rstn", div_rst_n, 0);
      check_val("load_busy", busy, 1);
      check_val("load_n", div_n, n);
      check_val("load_m", div_m, ms);
      check_val("load_idx", step_idx, 0);
      check_val("load_err", err, 0);
      check_val("load_done", done, 0);
      cyc(e);
    end

    k = 0; pass = 0; exp_done = 1'b0;
    forever begin
      cnt = 0; budget = 0;
      forever begin
        check_val("run_m", div_m, mv[k]);
        check_val("run_idx", step_idx, k);
        check_val("run_rstn", div_rst_n, 1);
        check_val("run_busy", busy, 1);
        check_val("run_done", done, exp_done);
        check_val("run_n", div_n, n);
        exp_done = 1'b0;
        if (e) cnt++;
        if (cnt == int'(dw_eff)) break;
        budget++;
        if (budget > 400) begin
          check_val("dwell_timeout", 0, 1);
          return;
        end
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1; cfg_n = $urandom; m_start = $urandom;
        end
        cyc(e);
      end
      cyc(e);
      check_val("step_m", div_m, mv[k]);
      check_val("step_busy", busy, 1);
      check_val("step_rstn", div_rst_n, 1);
      check_val("step_done", done, 0);
      cyc(e);
      if (k == int'(mcnt) - 1) begin
`ifdef FRAC_SWEEP_LOOP_EN
        pass++; k = 0; exp_done = 1'b1;
        if (pass >= LOOP_PASSES) begin
          check_val("loop_done", done, 1);
          check_val("loop_m", div_m, mv[0]);
          check_val("loop_idx", step_idx, 0);
          check_val("loop_busy", busy, 1);
          abort = 1'b1;
          cyc(e);
          check_val("loop_abort_busy", busy, 0);
          check_val("loop_abort_rstn", div_rst_n, 0);
          check_val("loop_abort_done", done, 0);
          check_val("loop_abort_m", div_m, mv[0]);
          return;
        end
`else
        check_val("done_pulse", done, 1);
        check_val("done_busy", busy, 0);
        check_val("done_rstn", div_rst_n, 1);
        check_val("done_m", div_m, mv[k]);
        check_val("done_idx", step_idx, k);
        cyc(e);
        check_val("done_once", done, 0);
        check_val("done_busy2", busy, 0);
        check_val("done_pass", pass, 0);
        return;
`endif
      end else if (k + 1 == err_at) begin
        check_val("step_err", err, 1);
        check_val("step_err_rstn", div_rst_n, 0);
        check_val("step_err_busy", busy, 0);
        check_val("step_err_idx", step_idx, k);
        check_val("step_err_m", div_m, mv[k]);
        check_val("step_err_done", done, 0);
        cyc(e);
        check_val("err_sticky", err, 1);
        return;
      end else begin
        k++;
      end
    end
  endtask

  initial begin
    logic [31:0] rn, rms, rstep, rdw;
    logic [15:0] rcnt;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_n = '0; m_start = '0; m_step = '0; m_count = '0; dwell = '0; div_clk = 1'b0;
    #2;
    check_reset_outs("rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(ev);
    check_reset_outs("idle");

    do_sweep(32'd9, 32'd1, 32'd1, 16'd3, 32'd4);
    do_sweep(32'd9, 32'd0, 32'd1, 16'd3, 32'd2);
    do_sweep(32'd9, 32'd11, 32'd1, 16'd3, 32'd2);
    do_sweep(32'd9, 32'd3, 32'd1, 16'd0, 32'd2);
    do_sweep(32'd9, 32'd8, 32'd2, 16'd3, 32'd1);

    abort = 1'b1;
    cyc(ev);
    check_val("abort_err_kept", err, 1);
    check_val("abort_err_busy", busy, 0);
    check_val("abort_err_rstn", div_rst_n, 0);

    do_sweep(32'd9, 32'd5, 32'd1, 16'd2, 32'd0);
    do_sweep(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd3, 16'd3, 32'd1);

    // Abort and start together while running.
    cfg_n = 32'd20; m_start = 32'd2; m_step = 32'd3; m_count = 16'd4; dwell = 32'd50;
    start = 1'b1;
    cyc(ev);
    repeat (4) cyc(ev);
    check_val("abrt_pre_busy", busy, 1);
    abort = 1'b1; start = 1'b1; cfg_n = 32'd7; m_start = 32'd1;
    cyc(ev);
    check_val("abrt_busy", busy, 0);
    check_val("abrt_rstn", div_rst_n, 0);
    check_val("abrt_done", done, 0);
    check_val("abrt_n", div_n, 20);
    check_val("abrt_m", div_m, 2);
    check_val("abrt_err", err, 0);
    repeat (3) begin
      cyc(ev);
      check_val("abrt_idle_busy", busy, 0);
      check_val("abrt_idle_done", done, 0);
      check_val("abrt_idle_rstn", div_rst_n, 0);
    end
    do_sweep(32'd20, 32'd2, 32'd3, 16'd4, 32'd2);

    // Asynchronous reset in the middle of a sweep, between clock edges.
    cfg_n = 32'd9; m_start = 32'd1; m_step = 32'd1; m_count = 16'd3; dwell = 32'd2;
    start = 1'b1;
    cyc(ev);
    repeat (8) cyc(ev);
    check_val("arst_pre_n", div_n, 9);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("arst");
    @(posedge clk);
    #1 check_reset_outs("arst_hold");
    #3 rst_n = 1'b1;
    cyc(ev);
    check_reset_outs("arst_rel");
    do_sweep(32'd9, 32'd1, 32'd1, 16'd3, 32'd2);

    for (int it = 0; it < 25; it++) begin
      rn    = $urandom_range(0, 20);
      rms   = $urandom_range(0, 24);
      rstep = $urandom_range(0, 6);
      rcnt  = 16'($urandom_range(0, 4));
      rdw   = $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0) begin
        rn    = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        rms   = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        rstep = $urandom_range(0, 8);
      end
      do_sweep(rn, rms, rstep, rcnt, rdw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_clk_sweep_ctrl.md
# frac_clk_sweep_ctrl

Sequencer for the fractional clock divider. It loads a divisor N and an increment M into the divider, holds the divider in reset while the values settle, then steps M through a programmed linear sweep. Each M value is held for a programmed number of output-clock edges. It sits between the register bank and the divider: it drives the divider's N, M and reset inputs and monitors the divider's output clock.

## Interface
Parameters:
- CW, 16: width of step count / step index.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a sweep from IDLE, DONE or ERR.
- abort  in  1  one-cycle pulse; stops any sweep.
- cfg_n  in  32  divisor N, sampled on accepted start.
- m_start  in  32  first M, sampled on accepted start.
- m_step  in  32  unsigned M increment per step, sampled on accepted start.
- m_count  in  CW  number of M values in the sweep, sampled on accepted start.
- dwell  in  32  output-clock edges per step, sampled on accepted start; 0 treated as 1.
- div_clk  in  1  divider output clock, same clock domain.
- div_n  out  32  N to divider.
- div_m  out  32  M to divider.
- div_rst_n  out  1  divider synchronous reset, active-low.
- busy  out  1  high in LOAD, RUN, STEP.
- done  out  1  one-cycle pulse on sweep completion.
- err  out  1  sticky config error; cleared by next accepted start.
- step_idx  out  CW  index of the M currently applied.

## Operation
- Edge: div_clk differs from its registered copy; both polarities count.
- Valid M: 1 ≤ M ≤ N+1. Comparison is 33-bit unsigned.
- States:
  - IDLE: on start, if m_count=0 or m_start is invalid → ERR. Otherwise latch inputs, div_n=cfg_n, div_m=m_start, step_idx=0 → LOAD.
  - LOAD: div_rst_n=0 for exactly 2 cycles → RUN. The edge counter is cleared.
  - RUN: div_rst_n=1. Count edges. On the edge that makes count = dwell → STEP.
  - STEP (1 cycle):
    - If step_idx = m_count-1 → DONE, with a done pulse.
    - Else compute next = div_m + m_step in 33 bits. If bit 32 is set or next is invalid → ERR. Otherwise div_m=next[31:0], step_idx+1, edge counter cleared → RUN. No divider reset between steps.
  - DONE: divider keeps running at the last M. start → revalidate/LOAD.
  - ERR: err=1, div_rst_n=0. start → revalidate/LOAD.
- abort in any state → IDLE next cycle. Effects: div_rst_n=0, busy=0, no done, err unchanged, div_n/div_m hold.
- abort and start in the same cycle: abort wins.
- start while busy is ignored.
- Async reset mid-sweep: all outputs go to reset values immediately. Sampled config is discarded.

## Timing
- Reset values: div_n=0, div_m=0, div_rst_n=0, busy=0, done=0, err=0, step_idx=0, state IDLE.
- Accepted start at cycle t: div_n/div_m valid and div_rst_n=0 at t+1 and t+2. div_rst_n=1 from t+3.
- Dwell edge at cycle e: STEP at e+1. The new div_m and step_idx are visible from e+2. done pulses at e+2 on the last step.
- Error detected at STEP cycle s: err=1 from s+1. Start-time error: err=1 from t+1, with no LOAD.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- FRAC_SWEEP_LOOP_EN defined: at the last step, STEP reloads div_m=m_start and step_idx=0, then returns to RUN with no divider reset. The sweep runs until abort, and done pulses once per completed pass.
- FRAC_SWEEP_LOOP_EN undefined: the sweep terminates in DONE as described above.

## Structure
- Package frac_sweep_pkg holds:
  - the state enum (IDLE, LOAD, RUN, STEP, DONE, ERR);
  - LOAD_CYCLES=2;
  - the 33-bit M-limit compare function.
- Sub-module frac_sweep_edge_cnt covers the div_clk edge detector, the 32-bit edge counter with clear, and dwell-reached compare (dwell 0→1).

## Test plan
- N=9, m_start=1, m_step=1, m_count=3, dwell=4 → div_m goes 1,2,3. Each value holds for 4 div_clk edges. done pulses once, 2 cycles after the 12th edge. busy=0 afterwards.
- Start with m_start=0, or with m_start=11 and N=9 → err=1 at t+1, div_rst_n stays 0, no LOAD.
- N=9, m_start=8, m_step=2, m_count=3 → second step computes 10 (valid, ≤10). Third step computes 12 → ERR. step_idx stays 1, err sticky until a valid start clears it.
- Abort during RUN with start asserted in the same cycle → IDLE next cycle, div_rst_n=0, no done. A later start runs normally.
- Assert rst_n low mid-step, asynchronously off the clock edge → all outputs reach reset values before the next clock edge.
- FRAC_SWEEP_LOOP_EN, m_count=2, dwell=1 → div_m alternates m_start, m_start+m_step indefinitely, with done pulsing every pass. Abort stops it.
